// File: rtl/display_pkg.sv
// Purpose: shared digit type, anode polarity and register sizing helper for the scan path.
// Latency: none (types and constants only).
// Backpressure: none.
package display_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Common-anode bank: a 1 on an anode enable turns the digit off.
  localparam logic ANODE_OFF = 1'b1;

  // Bits needed to hold 0..n-1. Never returns less than 1, so a one-digit
  // bank or a tiny divider still gets a real register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Purpose: refresh divider and slot pointer; flags the frame wrap and the per-slot guard window.
// Latency: frame_bnd and in_guard are combinational from the current div_cnt/slot state.
// Backpressure: none; free-running from reset.
module scan_divider
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16,
  localparam int SLOT_W      = clog2(NUM_DIGITS),
  localparam int DIV_W       = clog2(REFRESH_DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_bnd,
  output logic              in_guard
);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  // Last cycle of a slot; the last cycle of the last slot is the frame boundary.
  assign div_wrap  = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign frame_bnd = div_wrap && (slot == SLOT_W'(NUM_DIGITS - 1));

  // First GUARD_CYCLES of each slot keep every anode dark so the previous
  // digit's segments cannot ghost onto the newly selected digit.
  assign in_guard  = (div_cnt < DIV_W'(GUARD_CYCLES));

  // Refresh divider: one full count per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Slot pointer: advance on every divider wrap, back to slot 0 at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (frame_bnd) begin
      slot <= '0;
    end else if (div_wrap) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Purpose: time-multiplexes a double-buffered packed BCD value onto a common-anode bank (LEADING_ZERO_BLANK_EN blanks leading zeros).
// Latency: outputs registered 1 cycle after divider state; a load becomes visible within NUM_DIGITS*REFRESH_DIV+2 cycles.
// Backpressure: none; load is always accepted, the last load before a frame boundary wins (busy shows an unapplied value).
module digit_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                          load,
  output logic [DIGIT_W-1:0]            digit,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          frame_start,
  output logic                          busy
);

  localparam int SLOT_W = clog2(NUM_DIGITS);
  localparam int BCD_W  = DIGIT_W * NUM_DIGITS;

  logic [BCD_W-1:0]      pending;
  logic                  pend;
  logic [BCD_W-1:0]      shadow;
  logic [SLOT_W-1:0]     slot;
  logic                  frame_bnd;
  logic                  in_guard;
  digit_t                cur_digit;
  logic [NUM_DIGITS-1:0] slot_sel;
  logic [NUM_DIGITS-1:0] lit_mask;
  logic [NUM_DIGITS-1:0] anode_n_next;

  scan_divider #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_scan_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot      (slot),
    .frame_bnd (frame_bnd),
    .in_guard  (in_guard)
  );

  // Capture buffer: every load overwrites, so back-to-back loads keep only the newest value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (load) begin
      pending <= bcd_in;
    end
  end

  // Pending flag: set by a load, cleared at the frame boundary. A load that
  // lands on the boundary goes straight to the shadow, so it never sets pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (frame_bnd) begin
      pend <= 1'b0;
    end else if (load) begin
      pend <= 1'b1;
    end
  end

  // Shadow register only changes at the frame boundary, so a frame never
  // mixes digits of two values. A same-cycle load beats the older pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (frame_bnd) begin
      if (load) begin
        shadow <= bcd_in;
      end else if (pend) begin
        shadow <= pending;
      end
    end
  end

  assign busy = pend;

  // Select the active slot's digit code and its one-hot anode position.
  always_comb begin
    cur_digit = '0;
    slot_sel  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot == SLOT_W'(i)) begin
        cur_digit   = shadow[i*DIGIT_W +: DIGIT_W];
        slot_sel[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [SLOT_W-1:0] msd;

  // Light only slots up to the most-significant nonzero shadow digit; slot 0
  // is always lit so an all-zero value still shows a single "0".
  always_comb begin
    msd      = '0;
    lit_mask = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (shadow[i*DIGIT_W +: DIGIT_W] != '0) begin
        msd = SLOT_W'(i);
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit_mask[i] = (i <= int'(msd));
    end
  end
`else
  assign lit_mask = '1;
`endif

  assign anode_n_next = in_guard ? {NUM_DIGITS{ANODE_OFF}} : ~(slot_sel & lit_mask);

  // Output stage: one register after the divider state, frame_start marks the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= '0;
      anode_n     <= {NUM_DIGITS{ANODE_OFF}};
      frame_start <= 1'b0;
    end else begin
      digit       <= cur_digit;
      anode_n     <= anode_n_next;
      frame_start <= frame_bnd;
    end
  end

endmodule
